pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Fetch/execute sequencer for the program counter. Holds the PC, issues instruction-memory
//   fetches with a req/ack handshake, and waits for the execute stage to complete.
//   Selects the next PC from halt, branch, increment, or (optional) call/return.
//   Sits between the instruction memory and the execute/control unit; its increment replaces the free-running PC+1.
// PARAMETERS
//   ADDR_W      5   PC / instruction address width
//   RESET_ADDR  0   PC value after reset and after restart from HALTED
//   STACK_DEPTH 4   return-stack entries (used only with PC_CALL_STACK_EN)
// PORTS
//   clkEN       in   1       clock, rising edge
//   rstN        in   1       asynchronous reset, active-low
//   start       in   1       begin execution (sampled in IDLE and HALTED only)
//   imemReq     out  1       fetch request
//   imemAddr    out  ADDR_W  fetch address (= pc)
//   imemAck     in   1       fetch accepted / instruction available
//   instrValid  out  1       one-cycle pulse: fetched instruction valid
//   execDone    in   1       execute stage finished current instruction
//   halt        in   1       stop after current instruction (sampled with execDone)
//   branchEn    in   1       take branch (sampled with execDone)
//   branchAddr  in   ADDR_W  branch / call target
//   callEn      in   1       call (sampled with execDone)
//   retEn       in   1       return (sampled with execDone)
//   pc          out  ADDR_W  current program counter
//   state       out  2       IDLE=00, FETCH=01, EXEC=10, HALTED=11
//   wrapFlag    out  1       sticky: PC incremented past 2^ADDR_W-1
//   stackErr    out  1       sticky: return-stack overflow/underflow
// BEHAVIOUR
// - rstN low, asynchronous:
//     state=IDLE, pc=RESET_ADDR, imemReq=0, instrValid=0, wrapFlag=0, stackErr=0, stack pointer=0.
//   Reset mid-FETCH drops imemReq immediately. All other outputs are registered.
// - imemReq = (state==FETCH); imemAddr = pc.
// - IDLE:
//     start=1 -> FETCH on the next edge.
// - FETCH:
//     - imemReq and imemAddr are held stable until imemAck is sampled high.
//     - Then -> EXEC, with instrValid=1 for exactly the first EXEC cycle.
//     - imemAck in any other state is ignored.
// - EXEC:
//     - Waits for execDone. On execDone, the next PC is chosen by priority:
//       halt > retEn > callEn > branchEn > increment.
//     - halt: -> HALTED, pc unchanged.
//     - branchEn: pc=branchAddr, -> FETCH.
//     - increment: pc=pc+1 mod 2^ADDR_W, -> FETCH. If pc was 2^ADDR_W-1, pc becomes 0 and wrapFlag is set.
//     - Minimum: 2 cycles per instruction (ack and execDone each asserted on their first cycle).
// - HALTED:
//     start=1 -> FETCH with pc=RESET_ADDR; wrapFlag and stackErr cleared.
// - start is ignored in FETCH and EXEC. execDone is ignored outside EXEC.
// - The control inputs halt, retEn, callEn and branchEn are don't-care unless execDone=1 in EXEC.
// CONFIGURATION
//   PC_CALL_STACK_EN defined: return stack of STACK_DEPTH x ADDR_W.
//     - callEn pushes pc+1 (mod 2^ADDR_W) and sets pc=branchAddr.
//     - retEn pops into pc.
//     - Call when full: no push, acts as a branch, stackErr set.
//     - Return when empty: acts as an increment, stackErr set.
//   PC_CALL_STACK_EN undefined: no stack storage.
//     - callEn and retEn are ignored (priority falls through to branchEn / increment).
//     - stackErr is tied to 0. Ports are unchanged.
// TESTING
//   1. Reset, start, imemAck=1 and execDone=1 whenever sampled
//        -> imemAddr 0,1,2,3 on successive FETCHs, one instrValid pulse each, 2 cycles per instruction.
//   2. imemAck delayed 3 cycles at pc=5
//        -> imemReq=1 and imemAddr=5 stable for 4 cycles; instrValid only after ack; pc stays 5.
//   3. pc=7, execDone with halt=1 and branchEn=1 (branchAddr=20)
//        -> HALTED, pc=7. Then start -> FETCH at 0, wrapFlag=0.
//   4. Drive branch to 31, then increment
//        -> pc=0, wrapFlag=1. wrapFlag stays 1 until reset or restart.
//   5. With PC_CALL_STACK_EN, at pc=3: callEn to 10, ret, ret
//        -> pc 10, 4, 5; stackErr=1 after the second ret.
//      Without the macro: same stimulus -> pc 4, 5, 6; stackErr=0.
//   6. rstN pulsed low during FETCH at pc=9 with ack pending
//        -> imemReq=0 same cycle, pc=0, state=IDLE; later ack is ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter fetch/execute sequencer.
// Holds the PC, fetches from instruction memory with a req/ack handshake,
// waits for the execute stage to finish, then picks the next PC from
// halt > return > call > branch > increment.
// Optional feature macro: PC_CALL_STACK_EN adds a STACK_DEPTH x ADDR_W
// return stack for call/return. Without it, callEn and retEn are ignored
// and stackErr is tied low.
module pc_sequencer #(
  parameter int              ADDR_W      = 5,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int              STACK_DEPTH = 4
) (
  input  logic              clkEN,
  input  logic              rstN,
  input  logic              start,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  output logic              instrValid,
  input  logic              execDone,
  input  logic              halt,
  input  logic              branchEn,
  input  logic [ADDR_W-1:0] branchAddr,
  input  logic              callEn,
  input  logic              retEn,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state,
  output logic              wrapFlag,
  output logic              stackErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    EXEC   = 2'b10,
    HALTED = 2'b11
  } stateT;

  stateT             curState;
  logic [ADDR_W-1:0] pcInc;
  logic              incWrap;
  logic [ADDR_W-1:0] nextPc;
  logic              setWrap;
  logic              stepEn;

  assign state    = curState;
  assign imemAddr = pc;
  assign pcInc    = pc + ADDR_W'(1);
  assign incWrap  = &pc;
  // An instruction retires without halting: the PC advances this edge.
  assign stepEn   = (curState == EXEC) && execDone && !halt;

`ifdef PC_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] stackMem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              stackFull;
  logic              stackEmpty;
  logic [IDX_W-1:0]  pushIdx;
  logic [IDX_W-1:0]  topIdx;
  logic              pushEn;
  logic              popEn;
  logic              setErr;

  assign stackFull  = (sp == SP_W'(STACK_DEPTH));
  assign stackEmpty = (sp == '0);
  assign pushIdx    = IDX_W'(sp);
  assign topIdx     = IDX_W'(sp - SP_W'(1));
`else
  logic unusedInputs;
  assign unusedInputs = callEn ^ retEn;
`endif

  // Next-PC selection for a retiring instruction (halt is handled in the FSM).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    nextPc  = pcInc;
    setWrap = incWrap;
`ifdef PC_CALL_STACK_EN
    pushEn  = 1'b0;
    popEn   = 1'b0;
    setErr  = 1'b0;
    if (retEn) begin
      if (!stackEmpty) begin
        nextPc  = stackMem[topIdx];
        setWrap = 1'b0;
        popEn   = 1'b1;
      end else begin
        setErr  = 1'b1;             // underflow: fall back to increment
      end
    end else if (callEn) begin
      nextPc  = branchAddr;
      setWrap = 1'b0;
      if (!stackFull) pushEn = 1'b1;
      else            setErr = 1'b1; // overflow: behaves as a plain branch
    end else
`endif
    if (branchEn) begin
      nextPc  = branchAddr;
      setWrap = 1'b0;
    end
  end

  // Sequencer FSM with registered handshake, valid pulse, PC and wrap flag.
  always_ff @(posedge clkEN or negedge rstN) begin
    if (!rstN) begin
      curState   <= IDLE;
      pc         <= RESET_ADDR;
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      wrapFlag   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      instrValid <= 1'b0;
      unique case (curState)
        IDLE: begin
          if (start) begin
            curState <= FETCH;
            imemReq  <= 1'b1;
          end
        end
        FETCH: begin
          if (imemAck) begin
            curState   <= EXEC;
            imemReq    <= 1'b0;
            instrValid <= 1'b1;
          end
        end
        EXEC: begin
          if (execDone) begin
            if (halt) begin
              curState <= HALTED;
            end else begin
              pc       <= nextPc;
              curState <= FETCH;
              imemReq  <= 1'b1;
              if (setWrap) wrapFlag <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (start) begin
            pc       <= RESET_ADDR;
            wrapFlag <= 1'b0;
            curState <= FETCH;
            imemReq  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_CALL_STACK_EN
  // Stack pointer and sticky error flag; restart clears the error only.
  always_ff @(posedge clkEN or negedge rstN) begin
    if (!rstN) begin
      sp       <= '0;
      stackErr <= 1'b0;
    end else begin
      if (curState == HALTED && start) stackErr <= 1'b0;
      else if (stepEn && setErr)       stackErr <= 1'b1;
      if (stepEn && pushEn)     sp <= sp + SP_W'(1);
      else if (stepEn && popEn) sp <= sp - SP_W'(1);
    end
  end

  // Return-address storage, written on a successful call.
  always_ff @(posedge clkEN) begin
    // NOTE: storage is not reset; sp alone decides which entries are valid.
    if (stepEn && pushEn) stackMem[pushIdx] <= pcInc;
  end
`else
  assign stackErr = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// transaction-level model (integer PC, queue as the return stack).
module tb_pc_sequencer;
  localparam int ADDR_W = 5;
  localparam int PC_MOD = 1 << ADDR_W;
  localparam int DEPTH  = 4;

  logic              clkEN = 1'b0;
  logic              rstN;
  logic              start, imemAck, execDone, halt, branchEn, callEn, retEn;
  logic [ADDR_W-1:0] branchAddr;
  logic              imemReq, instrValid, wrapFlag, stackErr;
  logic [ADDR_W-1:0] imemAddr, pc;
  logic [1:0]        state;

  int passCount  = 0;
  int checkCount = 0;
  bit compareEn  = 1'b0;

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_ADDR('0), .STACK_DEPTH(DEPTH)) dut (
    .clkEN(clkEN), .rstN(rstN), .start(start),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
    .instrValid(instrValid), .execDone(execDone), .halt(halt),
    .branchEn(branchEn), .branchAddr(branchAddr),
    .callEn(callEn), .retEn(retEn),
    .pc(pc), .state(state), .wrapFlag(wrapFlag), .stackErr(stackErr)
  );

  always #5 clkEN = ~clkEN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // States are the spec's codes: 0 idle, 1 fetch, 2 exec, 3 halted.
  int mState = 0;
  int mPc    = 0;
  bit mValid = 0;
  bit mWrap  = 0;
  bit mErr   = 0;
  int mStack[$];

  function automatic void modelIncrement();
    if (mPc == PC_MOD - 1) begin
      mPc   = 0;
      mWrap = 1;
    end else begin
      mPc = mPc + 1;
    end
  endfunction

  always @(posedge clkEN or negedge rstN) begin
    if (!rstN) begin
      mState = 0; mPc = 0; mValid = 0; mWrap = 0; mErr = 0;
      mStack.delete();
    end else begin
      mValid = 0;
      case (mState)
        0: if (start) mState = 1;
        1: if (imemAck) begin mState = 2; mValid = 1; end
        2: if (execDone) begin
             if (halt) mState = 3;
             else begin
               mState = 1;
`ifdef PC_CALL_STACK_EN
               if (retEn) begin
                 if (mStack.size() > 0) mPc = mStack.pop_back();
                 else begin mErr = 1; modelIncrement(); end
               end else if (callEn) begin
                 if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % PC_MOD);
                 else mErr = 1;
                 mPc = int'(branchAddr);
               end else
`endif
               if (branchEn) mPc = int'(branchAddr);
               else modelIncrement();
             end
           end
        3: if (start) begin mState = 1; mPc = 0; mWrap = 0; mErr = 0; end
        default: ;
      endcase
    end
  end

  // Cycle compare on the falling edge, away from the active edge.
  always @(negedge clkEN) begin
    if (compareEn) begin
      check("model_cmp {state,pc,req,addr,valid,wrap,err}",
            {16'd0, state, pc, imemReq, imemAddr, instrValid, wrapFlag, stackErr},
            {16'd0, 2'(mState), 5'(mPc), (mState == 1), 5'(mPc), mValid, mWrap, mErr});
    end
  end

  task automatic tick();
    @(posedge clkEN);
    #1;
  endtask

  initial begin
    int expA, expB, expC;
    bit expErr;
    rstN = 1'b0; start = 0; imemAck = 0; execDone = 0; halt = 0;
    branchEn = 0; callEn = 0; retEn = 0; branchAddr = '0;
    tick(); tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_req", 32'(imemReq), 32'd0);
    check("reset_flags", {30'd0, wrapFlag, stackErr}, 32'd0);
    compareEn = 1'b1;
    rstN = 1'b1;

    // 1: back-to-back instructions, two cycles each
    start = 1; imemAck = 1; execDone = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_fetch_addr", 32'(imemAddr), 32'(i));
      check("t1_fetch_req", {31'd0, imemReq}, 32'd1);
      tick();
      check("t1_valid_pulse", {31'd0, instrValid}, 32'd1);
    end
    start = 0; imemAck = 0;

    // 2: ack withheld three cycles at pc=5
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_hold", {24'd0, imemReq, instrValid, 1'b0, imemAddr}, {24'd0, 1'b1, 1'b0, 1'b0, 5'd5});
      if (k == 3) imemAck = 1;
      tick();
    end
    check("t2_valid_after_ack", {24'd0, instrValid, 2'b0, pc}, {24'd0, 1'b1, 2'b0, 5'd5});

    // 3: halt beats branch at pc=7, then restart
    tick(); tick(); tick(); tick();
    check("t3_at_pc7", {24'd0, state, 1'b0, pc}, {24'd0, 2'd2, 1'b0, 5'd7});
    halt = 1; branchEn = 1; branchAddr = 5'd20;
    tick();
    check("t3_halted", {24'd0, state, 1'b0, pc}, {24'd0, 2'd3, 1'b0, 5'd7});
    halt = 0; branchEn = 0; start = 1;
    tick();
    check("t3_restart", {16'd0, state, pc, wrapFlag}, {16'd0, 2'd1, 5'd0, 1'b0});
    start = 0;

    // 4: branch to 31 then increment wraps
    tick();
    branchEn = 1; branchAddr = 5'd31;
    tick();
    check("t4_branch31", 32'(pc), 32'd31);
    branchEn = 0;
    tick(); tick();
    check("t4_wrap", {16'd0, pc, wrapFlag}, {16'd0, 5'd0, 1'b1});
    tick(); tick();
    check("t4_wrap_sticky", {31'd0, wrapFlag}, 32'd1);
    tick();
    halt = 1;
    tick();
    check("t4_wrap_halted", {29'd0, state, wrapFlag}, {29'd0, 2'd3, 1'b1});
    halt = 0; start = 1;
    tick();
    check("t4_wrap_cleared", {16'd0, pc, wrapFlag}, {16'd0, 5'd0, 1'b0});
    start = 0;

    // 5: call to 10 at pc=3, then two returns
`ifdef PC_CALL_STACK_EN
    expA = 10; expB = 4; expC = 5; expErr = 1;
`else
    expA = 4;  expB = 5; expC = 6; expErr = 0;
`endif
    for (int i = 0; i < 7; i++) tick();
    check("t5_at_pc3", {24'd0, state, 1'b0, pc}, {24'd0, 2'd2, 1'b0, 5'd3});
    callEn = 1; branchAddr = 5'd10;
    tick();
    check("t5_call", 32'(pc), 32'(expA));
    callEn = 0;
    tick();
    retEn = 1;
    tick();
    check("t5_ret1", 32'(pc), 32'(expB));
    tick(); tick();
    check("t5_ret2", {16'd0, pc, stackErr}, {16'd0, 5'(expC), expErr});
    retEn = 0;

    // 6: reset during a pending fetch at pc=9
    tick();
    branchEn = 1; branchAddr = 5'd9;
    tick();
    branchEn = 0; imemAck = 0;
    tick();
    check("t6_pending", {24'd0, imemReq, 2'b0, imemAddr}, {24'd0, 1'b1, 2'b0, 5'd9});
    #2 rstN = 1'b0;
    #1 check("t6_async_reset", {24'd0, imemReq, state, pc}, {24'd0, 1'b0, 2'd0, 5'd0});
    imemAck = 1;
    tick();
    rstN = 1'b1;
    tick();
    check("t6_ack_ignored", {29'd0, imemReq, state}, 32'd0);

    // Randomized phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(0, 2) == 0);
      imemAck    = ($urandom_range(0, 1) == 0);
      execDone   = ($urandom_range(0, 1) == 0);
      halt       = ($urandom_range(0, 7) == 0);
      retEn      = ($urandom_range(0, 5) == 0);
      callEn     = ($urandom_range(0, 4) == 0);
      branchEn   = ($urandom_range(0, 3) == 0);
      branchAddr = ADDR_W'($urandom_range(0, PC_MOD - 1));
      rstN       = ($urandom_range(0, 499) != 0);
      tick();
    end
    rstN = 1'b1;
    tick();
    compareEn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
